// File: rtl/pc_sequencer_if.sv
// Bundle of fetch, execute and next-PC signals around the PC sequencer.
// master = the sequencer itself; slave = memory/datapath side.
interface pc_sequencer_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic        commit;
    logic        stall;
    logic        halted;
    logic        trap;
    logic [31:0] trap_pc;
    logic [31:0] retired;

    modport master (
        output imem_req, imem_addr, instr, instr_valid, pc,
               halted, trap, trap_pc, retired,
        input  imem_ack, imem_rdata, next_pc, commit, stall
    );

    modport slave (
        input  imem_req, imem_addr, instr, instr_valid, pc,
               halted, trap, trap_pc, retired,
        output imem_ack, imem_rdata, next_pc, commit, stall
    );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch/execute/commit controller owning the architectural PC.
// Optional PC_TRAP_EN: misaligned commit targets trap and halt instead of being truncated.
//
// Handshakes: imem_req is held (with imem_addr stable) until a cycle with imem_ack=1;
// the instruction is then offered with instr_valid=1 until a cycle with commit=1 and
// stall=0. Acks outside fetch and commits outside execute are ignored.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC  = 32'h0000_1000,
    parameter logic [31:0] EBREAK_OP = 32'h0010_0073
) (
    input  logic                 clk,
    input  logic                 rst,
    pc_sequencer_if.master       bus,
    output logic [1:0]           dbg_state
);

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] retired_q, retired_d;
    logic        trap_q, trap_d;
    logic [31:0] trap_pc_q, trap_pc_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_RESET;
            pc_q      <= RESET_PC;
            instr_q   <= 32'd0;
            retired_q <= 32'd0;
            trap_q    <= 1'b0;
            trap_pc_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            retired_q <= retired_d;
            trap_q    <= trap_d;
            trap_pc_q <= trap_pc_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        retired_d = retired_q;
        trap_d    = trap_q;
        trap_pc_d = trap_pc_q;
        case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH: begin
                if (bus.imem_ack) begin
                    instr_d = bus.imem_rdata;
                    if (bus.imem_rdata == EBREAK_OP) state_d = S_HALT;
                    else                             state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (bus.commit && !bus.stall) begin
`ifdef PC_TRAP_EN
                    // A misaligned target never reaches the PC; it is reported and the core stops.
                    if (bus.next_pc[1:0] != 2'b00) begin
                        trap_d    = 1'b1;
                        trap_pc_d = bus.next_pc;
                        state_d   = S_HALT;
                    end else begin
                        pc_d      = bus.next_pc;
                        retired_d = retired_q + 32'd1;
                        state_d   = S_FETCH;
                    end
`else
                    pc_d      = bus.next_pc & ~32'h0000_0003;
                    retired_d = retired_q + 32'd1;
                    state_d   = S_FETCH;
`endif
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_RESET;
        endcase
    end

    always_comb begin
        bus.imem_req    = (state_q == S_FETCH);
        bus.imem_addr   = pc_q;
        bus.instr       = instr_q;
        bus.instr_valid = (state_q == S_EXEC);
        bus.pc          = pc_q;
        bus.halted      = (state_q == S_HALT);
        bus.trap        = trap_q;
        bus.trap_pc     = trap_pc_q;
        bus.retired     = retired_q;
        dbg_state       = state_q;
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized instruction stream,
// with a queue-based scoreboard fed by the drivers and drained by a negedge monitor.
module tb_pc_sequencer;

    localparam logic [31:0] RESET_PC = 32'h0000_1000;
    localparam logic [31:0] EBREAK   = 32'h0010_0073;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] dbg_state;

    pc_sequencer_if bus ();

    pc_sequencer #(.RESET_PC(RESET_PC), .EBREAK_OP(EBREAK)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_fetch_q[$];
    logic [95:0] exp_exec_q[$];

    logic [31:0] model_pc;
    logic [31:0] model_retired;
    logic [31:0] model_instr;
    logic        model_halted;
    logic        model_trap;
    logic [31:0] model_trap_pc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a new fetch or a new execute window pops the oldest prediction.
    logic        prev_req = 1'b0;
    logic        prev_valid = 1'b0;
    logic [31:0] mon_addr;
    logic [95:0] mon_exec;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.imem_req && !prev_req) begin
                if (exp_fetch_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL fetch_unexpected: got addr %h expected no fetch at %0t", bus.imem_addr, $time);
                end else begin
                    mon_addr = exp_fetch_q.pop_front();
                    check("fetch_addr", bus.imem_addr, mon_addr);
                    check("fetch_pc", bus.pc, mon_addr);
                end
            end
            if (bus.instr_valid && !prev_valid) begin
                if (exp_exec_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL exec_unexpected: got instr %h expected no execute at %0t", bus.instr, $time);
                end else begin
                    mon_exec = exp_exec_q.pop_front();
                    check("exec_instr", bus.instr, mon_exec[95:64]);
                    check("exec_pc", bus.pc, mon_exec[63:32]);
                    check("exec_retired", bus.retired, mon_exec[31:0]);
                end
            end
        end
        prev_req   = bus.imem_req;
        prev_valid = bus.instr_valid;
    end

    task automatic do_reset(input int cycles, input bit ack_during);
        @(posedge clk); #1;
        rst          = 1'b1;
        bus.commit   = 1'b0;
        bus.stall    = 1'b0;
        bus.imem_ack = ack_during;
        bus.imem_rdata = 32'hDEAD_BEEF;
        repeat (cycles) @(posedge clk);
        #1;
        check("rst_req", 32'(bus.imem_req), 32'd0);
        check("rst_valid", 32'(bus.instr_valid), 32'd0);
        check("rst_pc", bus.pc, RESET_PC);
        check("rst_instr", bus.instr, 32'd0);
        check("rst_retired", bus.retired, 32'd0);
        check("rst_halted", 32'(bus.halted), 32'd0);
        check("rst_trap", 32'(bus.trap), 32'd0);
        check("rst_trap_pc", bus.trap_pc, 32'd0);
        exp_fetch_q.delete();
        exp_exec_q.delete();
        model_pc      = RESET_PC;
        model_retired = 32'd0;
        model_instr   = 32'd0;
        model_halted  = 1'b0;
        model_trap    = 1'b0;
        model_trap_pc = 32'd0;
        exp_fetch_q.push_back(RESET_PC);
        bus.imem_ack = 1'b0;
        rst = 1'b0;
        check("post_rst_idle_req", 32'(bus.imem_req), 32'd0);
        @(posedge clk); #1;
        check("post_rst_req", 32'(bus.imem_req), 32'd1);
        check("post_rst_addr", bus.imem_addr, RESET_PC);
    endtask

    task automatic do_fetch(input logic [31:0] rdata, input int delay);
        int w = 0;
        while (!bus.imem_req && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        check("fetch_ready", 32'(bus.imem_req), 32'd1);
        if (!bus.imem_req) return;
        repeat (delay) begin
            @(posedge clk); #1;
            check("wait_req", 32'(bus.imem_req), 32'd1);
            check("wait_addr", bus.imem_addr, model_pc);
        end
        if (rdata != EBREAK) exp_exec_q.push_back({rdata, model_pc, model_retired});
        model_instr    = rdata;
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = rdata;
        @(posedge clk); #1;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = $urandom;
        if (rdata == EBREAK) begin
            model_halted = 1'b1;
            check("ebreak_halted", 32'(bus.halted), 32'd1);
            check("ebreak_req", 32'(bus.imem_req), 32'd0);
            check("ebreak_valid", 32'(bus.instr_valid), 32'd0);
        end else begin
            check("fetch_valid", 32'(bus.instr_valid), 32'd1);
            check("fetch_instr", bus.instr, rdata);
        end
    endtask

    task automatic do_commit(input logic [31:0] npc, input int stall_cycles, input bit noise);
        check("exec_ready", 32'(bus.instr_valid), 32'd1);
        if (!bus.instr_valid) return;
        bus.next_pc = npc;
        bus.commit  = 1'b1;
        bus.stall   = 1'b1;
        repeat (stall_cycles) begin
            if (noise) begin
                bus.imem_ack   = 1'($urandom_range(0, 1));
                bus.imem_rdata = $urandom;
            end
            @(posedge clk); #1;
            check("stall_pc", bus.pc, model_pc);
            check("stall_valid", 32'(bus.instr_valid), 32'd1);
            check("stall_instr", bus.instr, model_instr);
            check("stall_retired", bus.retired, model_retired);
        end
        bus.stall    = 1'b0;
        bus.imem_ack = 1'b0;
`ifdef PC_TRAP_EN
        if (npc[1:0] != 2'b00) begin
            model_trap    = 1'b1;
            model_trap_pc = npc;
            model_halted  = 1'b1;
        end else begin
            model_pc      = npc;
            model_retired = model_retired + 32'd1;
            exp_fetch_q.push_back(model_pc);
        end
`else
        model_pc      = {npc[31:2], 2'b00};
        model_retired = model_retired + 32'd1;
        exp_fetch_q.push_back(model_pc);
`endif
        @(posedge clk); #1;
        bus.commit = 1'b0;
        check("commit_pc", bus.pc, model_pc);
        check("commit_retired", bus.retired, model_retired);
        check("commit_halted", 32'(bus.halted), 32'(model_halted));
        check("commit_trap", 32'(bus.trap), 32'(model_trap));
        check("commit_trap_pc", bus.trap_pc, model_trap_pc);
        if (!model_halted) begin
            check("commit_next_req", 32'(bus.imem_req), 32'd1);
            check("commit_next_addr", bus.imem_addr, model_pc);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rdata;
        logic [31:0] npc;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'd0;
        bus.next_pc    = 32'd0;
        bus.commit     = 1'b0;
        bus.stall      = 1'b0;

        // Reset, delayed first fetch, stalled then accepted commit.
        do_reset(2, 1'b0);
        do_fetch(32'h0000_0013, 3);
        do_commit(32'h0000_1004, 2, 1'b0);

        // Randomized instruction stream.
        for (int i = 0; i < 24; i++) begin
            rdata = $urandom;
            if (rdata == EBREAK) rdata = rdata ^ 32'h1;
            do_fetch(rdata, $urandom_range(0, 3));
            npc = $urandom;
            case ($urandom_range(0, 3))
                0, 1:    npc = model_pc + 32'd4;
                2:       npc[1:0] = 2'b00;
                default: begin
`ifdef PC_TRAP_EN
                    npc[1:0] = 2'b00;
`endif
                end
            endcase
            do_commit(npc, $urandom_range(0, 2), 1'b1);
        end

        // Misaligned commit target.
        do_reset(1, 1'b0);
        do_fetch(32'h0000_0013, 0);
        do_commit(32'h0000_1004, 0, 1'b0);
        do_fetch(32'h0000_0013, 1);
        do_commit(32'h0000_1006, 0, 1'b0);
        check("misalign_pc", bus.pc, 32'h0000_1004);
`ifdef PC_TRAP_EN
        check("misalign_trap", 32'(bus.trap), 32'd1);
        check("misalign_trap_pc", bus.trap_pc, 32'h0000_1006);
`else
        check("misalign_trap", 32'(bus.trap), 32'd0);
        do_fetch(32'h0000_0093, 0);
`endif

        // Reset while a fetch is outstanding, with an ack arriving during reset.
        do_reset(1, 1'b0);
        repeat (2) begin
            @(posedge clk); #1;
        end
        do_reset(2, 1'b1);
        do_fetch(32'h0000_0113, 1);

        // EBREAK halts; commits, stalls and acks are ignored afterwards.
        do_commit(32'h0000_2000, 0, 1'b0);
        do_fetch(EBREAK, 2);
        repeat (10) begin
            bus.commit     = 1'($urandom_range(0, 1));
            bus.stall      = 1'($urandom_range(0, 1));
            bus.imem_ack   = 1'($urandom_range(0, 1));
            bus.imem_rdata = $urandom;
            bus.next_pc    = $urandom;
            @(posedge clk); #1;
            check("halt_req", 32'(bus.imem_req), 32'd0);
            check("halt_halted", 32'(bus.halted), 32'd1);
            check("halt_valid", 32'(bus.instr_valid), 32'd0);
            check("halt_retired", bus.retired, model_retired);
            check("halt_pc", bus.pc, model_pc);
            check("halt_instr", bus.instr, EBREAK);
        end
        bus.commit   = 1'b0;
        bus.stall    = 1'b0;
        bus.imem_ack = 1'b0;
        repeat (2) @(negedge clk);

        check("fetch_queue_drained", exp_fetch_q.size(), 32'd0);
        check("exec_queue_drained", exp_exec_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
